// File: rtl/elastic_pipe_pkg.sv
// rtl/elastic_pipe_pkg.sv - shared constants and width helper for the elastic pipeline
package elastic_pipe_pkg;

    localparam int STALL_CNT_W = 32;

    // Width needed to count 0..length valid stages.
    function automatic int clog2_occ(input int length);
        return (length < 1) ? 1 : $clog2(length + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// rtl/elastic_pipe_stage.sv - one valid/data register pair of the elastic pipeline
module elastic_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    logic             valid_d;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = in_valid;
            // Data only moves with a real payload so bubbles leave it untouched.
            if (in_valid) begin
                data_d = in_data;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// rtl/elastic_pipeline.sv - LENGTH-stage valid/ready elastic pipeline; ELASTIC_PIPE_STATS_EN adds stall_cnt
module elastic_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter  int LENGTH = 1,
    parameter  int WIDTH  = 1,
    localparam int OCC_W  = clog2_occ(LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
`ifdef ELASTIC_PIPE_STATS_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [OCC_W-1:0]       occupancy
);

    logic [LENGTH-1:0] v;
    logic [LENGTH-1:0] adv;
    logic [LENGTH-1:0] load;
    logic [WIDTH-1:0]  d [LENGTH];
    logic [OCC_W-1:0]  occ_d, occ_q;
    logic              accept, emit;

    // adv[i]: stage i's payload can leave; an empty stage may always load.
    always_comb begin
        adv             = '0;
        adv[LENGTH-1]   = out_ready;
        for (int i = LENGTH - 2; i >= 0; i--) begin
            adv[i] = !v[i+1] || adv[i+1];
        end
        load = ~v | adv;
    end

    genvar g;
    generate
        for (g = 0; g < LENGTH; g++) begin : g_stage
            logic             stage_in_valid;
            logic [WIDTH-1:0] stage_in_data;
            if (g == 0) begin : g_head
                assign stage_in_valid = in_valid;
                assign stage_in_data  = in_data;
            end else begin : g_body
                assign stage_in_valid = v[g-1];
                assign stage_in_data  = d[g-1];
            end
            elastic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .load     (load[g]),
                .in_valid (stage_in_valid),
                .in_data  (stage_in_data),
                .valid_q  (v[g]),
                .data_q   (d[g])
            );
        end
    endgenerate

    assign in_ready  = load[0];
    assign out_valid = v[LENGTH-1];
    assign out_data  = d[LENGTH-1];
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign occupancy = occ_q;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !emit) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (emit && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef ELASTIC_PIPE_STATS_EN
    logic [STALL_CNT_W-1:0] stall_d, stall_q;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb/tb_elastic_pipeline.sv - directed self-checking bench for elastic_pipeline (LENGTH=4, WIDTH=8)
module tb_elastic_pipeline;

    localparam int LENGTH = 4;
    localparam int WIDTH  = 8;
    localparam int OCC_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;
`ifdef ELASTIC_PIPE_STATS_EN
    logic [31:0]      stall_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    elastic_pipeline #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ELASTIC_PIPE_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);

        // Streaming: accept 1..8, output appears 4 edges after accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            in_data = WIDTH'(j);
            tick();
            if (j == 3) chk("stream_not_yet", {31'd0, out_valid}, 32'd0);
            if (j >= 4) begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_data", {24'd0, out_data}, j - 3);
                chk("stream_occ", {29'd0, occupancy}, 32'd4);
            end
        end
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        chk("drain_occ", {29'd0, occupancy}, 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = WIDTH'(8'hA0 + j);
            tick();
        end
        chk("bp_full_occ", {29'd0, occupancy}, 32'd4);
        in_data = 8'hEE;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("bp_hold_data", {24'd0, out_data}, 32'hA0);
            chk("bp_hold_occ", {29'd0, occupancy}, 32'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_drain_data", {24'd0, out_data}, 32'hA0 + k);
            tick();
        end
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("bp_empty_occ", {29'd0, occupancy}, 32'd0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 8'h22;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        chk("bub_head", {24'd0, out_data}, 32'h11);
        chk("bub_occ", {29'd0, occupancy}, 32'd2);
        in_valid = 1'b1;
        in_data  = 8'h33;
        #1;
        chk("bub_ready_a", {31'd0, in_ready}, 32'd1);
        tick();
        in_data = 8'h44;
        #1;
        chk("bub_ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bub_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bub_full_occ", {29'd0, occupancy}, 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bub_drain", {24'd0, out_data}, 32'h11 * (k + 1));
            tick();
        end

        // Flush with three in flight and a concurrent input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = WIDTH'(8'h61 + j);
            tick();
        end
        chk("fl_pre_occ", {29'd0, occupancy}, 32'd3);
        flush   = 1'b1;
        in_data = 8'h55;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ", {29'd0, occupancy}, 32'd0);
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("fl_no_output", {31'd0, out_valid}, 32'd0);
        end

`ifdef ELASTIC_PIPE_STATS_EN
        // Stall counter
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        chk("st_valid", {31'd0, out_valid}, 32'd1);
        chk("st_zero", stall_cnt, 32'd0);
        for (int j = 0; j < 7; j++) tick();
        chk("st_seven", stall_cnt, 32'd7);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_flush_keeps", stall_cnt, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("st_rst_clears", stall_cnt, 32'd0);
`endif

        // Reset mid-stream drops everything
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        for (int j = 0; j < 4; j++) tick();
        chk("mid_full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_occ", {29'd0, occupancy}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("mid_no_output", {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
